dbg_inst_gen: RTL and testbench



---
 rtl/dbg_inst_gen_pkg.sv | 57 +++++
 rtl/dbg_inst_gen_rv_enc.sv | 30 +++
 rtl/dbg_inst_gen.sv | 160 ++++++++++++++++
 tb/tb_dbg_inst_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_inst_gen_pkg.sv
// Shared definitions for the debug instruction generator: RV32I opcode and
// funct3 codes, command op encodings, sequencer state encodings, and the
// sequence-order function that gives the state following any state for each
// command type.
package dbg_inst_gen_pkg;

  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_OPIMM  = 7'b0010011;
  localparam logic [6:0] INST_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_STORE  = 7'b0100011;
  localparam logic [6:0] INST_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_SW    = 3'b010;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  typedef enum logic [1:0] {
    OP_REGW = 2'b00,
    OP_MEMW = 2'b01,
    OP_MEMR = 2'b10,
    OP_CSRW = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A_HI = 3'd1,
    S_A_LO = 3'd2,
    S_D_HI = 3'd3,
    S_D_LO = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  // Instruction format selected for the word being encoded.
  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_U    = 2'd1,
    FMT_I    = 2'd2,
    FMT_S    = 2'd3
  } fmt_e;

  // State that follows s in the word sequence for op; S_IDLE ends it.
  function automatic state_e seq_next(cmd_op_e op, state_e s);
    state_e n;
    n = S_IDLE;
    case (s)
      S_IDLE: n = (op == OP_MEMW || op == OP_MEMR) ? S_A_HI : S_D_HI;
      S_A_HI: n = S_A_LO;
      S_A_LO: n = (op == OP_MEMW) ? S_D_HI : S_FIN;
      S_D_HI: n = S_D_LO;
      S_D_LO: n = (op == OP_REGW) ? S_IDLE : S_FIN;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dbg_inst_gen_rv_enc.sv
// rv_enc: combinational RV32I field packers plus the LUI/ADDI constant split.
//   i_val            value to split; o_hi = (i_val + 0x800) >> 12, o_lo = i_val[11:0]
//   i_opcode/i_funct3/i_rd/i_rs1/i_rs2/i_imm12/i_imm20  instruction fields
//   o_u/o_i/o_s      U-, I- and S-type words built from those fields
module rv_enc (
  input  logic [31:0] i_val,
  output logic [19:0] o_hi,
  output logic [11:0] o_lo,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [11:0] i_imm12,
  input  logic [19:0] i_imm20,
  output logic [31:0] o_u,
  output logic [31:0] o_i,
  output logic [31:0] o_s
);
  logic [31:0] w_rnd;

  // Rounding by 0x800 pre-compensates for ADDI sign-extending bit 11 of lo.
  assign w_rnd = i_val + 32'h0000_0800;
  assign o_hi  = w_rnd[31:12];
  assign o_lo  = i_val[11:0];

  assign o_u = {i_imm20, i_rd, i_opcode};
  assign o_i = {i_imm12, i_rs1, i_funct3, i_rd, i_opcode};
  assign o_s = {i_imm12[11:5], i_rs2, i_rs1, i_funct3, i_imm12[4:0], i_opcode};
endmodule

// File: rtl/dbg_inst_gen.sv
// dbg_inst_gen: expands one debug command (REGW/MEMW/MEMR/CSRW) into a short
// fixed RV32I word sequence streamed over a valid/ready handshake.
//   clk, rst                        clock, async active-high reset
//   cmd_valid_i/cmd_ready_o         command handshake (ready only in IDLE)
//   cmd_op_i, cmd_rd_i, cmd_addr_i, cmd_data_i   command fields, latched on accept
//   inst_valid_o/inst_ready_i       instruction handshake
//   inst_o, inst_last_o             registered word and end-of-sequence flag
//   busy_o                          sequence in progress
module dbg_inst_gen
  import dbg_inst_gen_pkg::*;
#(
  parameter logic [4:0] TMP_ADDR_REG = 5'd5,
  parameter logic [4:0] TMP_DATA_REG = 5'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic        inst_last_o,
  output logic        busy_o
);
  state_e      r_state, w_state_nxt, w_after;
  cmd_op_e     r_op, w_op;
  logic [4:0]  r_rd, w_rd, w_dst;
  logic [31:0] r_addr, r_data, r_inst, w_addr, w_data, w_val, w_word;
  logic        r_last, w_accept, w_adv;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_erd, w_rs1, w_rs2;
  logic [11:0] w_imm12, w_lo;
  logic [19:0] w_hi;
  logic [31:0] w_u, w_i, w_s;
  fmt_e        w_fmt;

  assign w_accept = (r_state == S_IDLE) && cmd_valid_i;
  assign w_adv    = (r_state != S_IDLE) && inst_ready_i;

  // The first word is encoded on the accept edge, before the latches update,
  // so the source fields bypass the latches in that cycle.
  assign w_op   = w_accept ? cmd_op_e'(cmd_op_i) : r_op;
  assign w_rd   = w_accept ? cmd_rd_i   : r_rd;
  assign w_addr = w_accept ? cmd_addr_i : r_addr;
  assign w_data = w_accept ? cmd_data_i : r_data;
  assign w_dst  = (w_op == OP_REGW) ? w_rd : TMP_DATA_REG;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept || w_adv) w_state_nxt = seq_next(w_op, r_state);
  end

  // The word being entered is last when the state after it is IDLE.
  assign w_after = seq_next(w_op, w_state_nxt);
  assign w_val   = (w_state_nxt == S_A_HI || w_state_nxt == S_A_LO) ? w_addr : w_data;

  always_comb begin
    w_opcode = INST_LUI;
    w_funct3 = 3'b000;
    w_erd    = 5'd0;
    w_rs1    = 5'd0;
    w_rs2    = 5'd0;
    w_imm12  = 12'd0;
    w_fmt    = FMT_NONE;
    case (w_state_nxt)
      S_A_HI: begin w_erd = TMP_ADDR_REG; w_fmt = FMT_U; end
      S_A_LO: begin
        w_opcode = INST_OPIMM; w_funct3 = F3_ADDI;
        w_erd = TMP_ADDR_REG; w_rs1 = TMP_ADDR_REG; w_imm12 = w_lo; w_fmt = FMT_I;
      end
      S_D_HI: begin w_erd = w_dst; w_fmt = FMT_U; end
      S_D_LO: begin
        w_opcode = INST_OPIMM; w_funct3 = F3_ADDI;
        w_erd = w_dst; w_rs1 = w_dst; w_imm12 = w_lo; w_fmt = FMT_I;
      end
      S_FIN: begin
        case (w_op)
          OP_MEMW: begin
            w_opcode = INST_STORE; w_funct3 = F3_SW;
            w_rs1 = TMP_ADDR_REG; w_rs2 = TMP_DATA_REG; w_fmt = FMT_S;
          end
          OP_MEMR: begin
            w_opcode = INST_LOAD; w_funct3 = F3_LW;
            w_erd = w_rd; w_rs1 = TMP_ADDR_REG; w_fmt = FMT_I;
          end
          default: begin
            w_opcode = INST_SYSTEM; w_funct3 = F3_CSRRW;
            w_rs1 = TMP_DATA_REG; w_imm12 = w_addr[11:0]; w_fmt = FMT_I;
          end
        endcase
      end
      default: w_fmt = FMT_NONE;
    endcase
  end

  rv_enc u_enc (
    .i_val    (w_val),
    .o_hi     (w_hi),
    .o_lo     (w_lo),
    .i_opcode (w_opcode),
    .i_funct3 (w_funct3),
    .i_rd     (w_erd),
    .i_rs1    (w_rs1),
    .i_rs2    (w_rs2),
    .i_imm12  (w_imm12),
    .i_imm20  (w_hi),
    .o_u      (w_u),
    .o_i      (w_i),
    .o_s      (w_s)
  );

  always_comb begin
    w_word = 32'd0;
    case (w_fmt)
      FMT_U:   w_word = w_u;
      FMT_I:   w_word = w_i;
      FMT_S:   w_word = w_s;
      default: w_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_REGW;
      r_rd   <= 5'd0;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_inst <= 32'd0;
      r_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd_op_e'(cmd_op_i);
        r_rd   <= cmd_rd_i;
        r_addr <= cmd_addr_i;
        r_data <= cmd_data_i;
      end
      if (w_accept || w_adv) begin
        r_inst <= w_word;
        r_last <= (w_state_nxt != S_IDLE) && (w_after == S_IDLE);
      end
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign inst_valid_o = (r_state != S_IDLE);
  assign inst_o       = r_inst;
  assign inst_last_o  = r_last;
endmodule

// File: tb/tb_dbg_inst_gen.sv
// Bench for dbg_inst_gen: known-answer table, hand sequences for reset and
// back-to-back commands, then random commands against a reference model.
module tb_dbg_inst_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_rd_i;
  logic [31:0] cmd_addr_i, cmd_data_i;
  logic        inst_valid_o, inst_ready_i, inst_last_o, busy_o;
  logic [31:0] inst_o;

  int n_tests = 0;
  int n_fail  = 0;
  int seq_id  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]       op;
    logic [4:0]       rd;
    logic [31:0]      addr;
    logic [31:0]      data;
    int               mode;
    int               n;
    logic [4:0][31:0] w;
  } vec_t;
  vec_t vecs[$];

  dbg_inst_gen dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_last_o(inst_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (seq %0d): got %h expected %h", name, seq_id, act, exp);
    end
  endtask

  // Reference encodings written straight from the instruction formats.
  function automatic logic [31:0] m_lui(input logic [4:0] r, input logic [31:0] v);
    return ((v + 32'h800) & 32'hFFFF_F000) | (32'(r) << 7) | 32'h37;
  endfunction
  function automatic logic [31:0] m_addi(input logic [4:0] r, input logic [31:0] v);
    return ((v & 32'hFFF) << 20) | (32'(r) << 15) | (32'(r) << 7) | 32'h13;
  endfunction
  function automatic logic [31:0] m_lw(input logic [4:0] rd);
    return (32'd5 << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
  endfunction
  function automatic logic [31:0] m_csrrw(input logic [31:0] a);
    return ((a & 32'hFFF) << 20) | (32'd6 << 15) | (32'd1 << 12) | 32'h73;
  endfunction

  task automatic build(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] d);
    logic [4:0] r;
    exp_q.delete();
    r = (op == 2'd0) ? rd : 5'd6;
    if (op == 2'd1 || op == 2'd2) begin
      exp_q.push_back(m_lui(5'd5, a));
      exp_q.push_back(m_addi(5'd5, a));
    end
    if (op != 2'd2) begin
      exp_q.push_back(m_lui(r, d));
      exp_q.push_back(m_addi(r, d));
    end
    case (op)
      2'd1: exp_q.push_back((32'd6 << 20) | (32'd5 << 15) | (32'd2 << 12) | 32'h23);
      2'd2: exp_q.push_back(m_lw(rd));
      2'd3: exp_q.push_back(m_csrrw(a));
      default: ;
    endcase
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] d, input int mode, input int n,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
    vec_t v;
    v.op = op; v.rd = rd; v.addr = a; v.data = d; v.mode = mode; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    vecs.push_back(v);
  endtask

  // Waits for cmd_ready, presents the command for one edge; returns at the
  // negedge after acceptance, where the first word must already be visible.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    int cyc = 0;
    seq_id++;
    while (!cmd_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk("cmd_ready_before_issue", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_rd_i = rd; cmd_addr_i = a; cmd_data_i = d;
    @(negedge clk);
    if (!hold) begin
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'($urandom_range(0, 3));
      cmd_rd_i    = 5'($urandom_range(0, 31));
      cmd_addr_i  = $urandom;
      cmd_data_i  = $urandom;
    end
    chk("first_word_latency", 32'(inst_valid_o), 32'd1);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode, input int stop_after);
    int idx = 0, cyc = 0, k = 0;
    logic stalled = 1'b0;
    logic [31:0] pw = 32'd0;
    logic pl = 1'b0, r;
    while (idx < exp_q.size() && idx < stop_after && cyc < 200) begin
      cyc++;
      chk("inst_valid_in_seq", 32'(inst_valid_o), 32'd1);
      if (!inst_valid_o) break;
      chk("cmd_ready_while_busy", 32'(cmd_ready_o), 32'd0);
      chk("busy_in_seq", 32'(busy_o), 32'd1);
      if (stalled) begin
        chk("stall_word_hold", inst_o, pw);
        chk("stall_last_hold", 32'(inst_last_o), 32'(pl));
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
      inst_ready_i = r;
      if (r) begin
        chk("word", inst_o, exp_q[idx]);
        chk("last_flag", 32'(inst_last_o), 32'(idx == exp_q.size() - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pw = inst_o;
        pl = inst_last_o;
      end
      @(negedge clk);
    end
    inst_ready_i = 1'b1;
    if (stop_after >= exp_q.size()) begin
      chk("word_count", 32'(idx), 32'(exp_q.size()));
      chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("idle_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("idle_busy", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] edges[6];
    logic [1:0]  rop;
    logic [4:0]  rrd;
    logic [31:0] ra, rdat;
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h0000_0800;
    edges[3] = 32'h7FFF_F7FF; edges[4] = 32'h8000_0000; edges[5] = 32'hFFFF_F800;

    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_rd_i = 5'd0;
    cmd_addr_i = 32'd0; cmd_data_i = 32'd0; inst_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("reset_inst", inst_o, 32'd0);
    chk("reset_last", 32'(inst_last_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    add_vec(2'd0, 5'd5, 32'h0, 32'h1234_5FFF, 0, 2,
            32'h1234_62B7, 32'hFFF2_8293, 0, 0, 0);
    add_vec(2'd1, 5'd0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 5,
            32'h1000_02B7, 32'h0042_8293, 32'hDEAD_C337, 32'hEEF3_0313, 32'h0062_A023);
    add_vec(2'd2, 5'd10, 32'h1000_0004, 32'h0, 1, 3,
            32'h1000_02B7, 32'h0042_8293, 32'h0002_A503, 0, 0);
    add_vec(2'd3, 5'd0, 32'h0000_0340, 32'h1, 0, 3,
            32'h0000_0337, 32'h0013_0313, 32'h3403_1073, 0, 0);
    add_vec(2'd0, 5'd0, 32'h0, 32'h0000_0800, 1, 2,
            32'h0000_1037, 32'h8000_0013, 0, 0, 0);
    add_vec(2'd0, 5'd31, 32'h0, 32'hFFFF_FFFF, 0, 2,
            32'h0000_0FB7, 32'hFFFF_8F93, 0, 0, 0);
    add_vec(2'd1, 5'd0, 32'h2000_0000, 32'h0, 2, 5,
            32'h2000_02B7, 32'h0002_8293, 32'h0000_0337, 32'h0003_0313, 32'h0062_A023);

    foreach (vecs[i]) begin
      exp_q.delete();
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].w[j]);
      issue(vecs[i].op, vecs[i].rd, vecs[i].addr, vecs[i].data, 1'b0);
      drain(vecs[i].mode, 99);
    end

    // Reset during the third word of a MEMW drops the rest of the sequence.
    build(2'd1, 5'd0, 32'h1000_0004, 32'hDEAD_BEEF);
    issue(2'd1, 5'd0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0);
    drain(0, 2);
    chk("pre_reset_third_word", inst_o, exp_q[2]);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(inst_valid_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_inst", inst_o, 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_words", 32'(inst_valid_o), 32'd0);
    end
    build(2'd0, 5'd5, 32'h0, 32'h1234_5FFF);
    issue(2'd0, 5'd5, 32'h0, 32'h1234_5FFF, 1'b0);
    drain(0, 99);

    // cmd_valid held high: second accept only after one IDLE cycle.
    build(2'd3, 5'd0, 32'h0000_0305, 32'h8000_0ABC);
    issue(2'd3, 5'd0, 32'h0000_0305, 32'h8000_0ABC, 1'b1);
    drain(2, 99);
    @(negedge clk);
    chk("b2b_second_accept", 32'(inst_valid_o), 32'd1);
    cmd_valid_i = 1'b0;
    drain(0, 99);

    for (int t = 0; t < 40; t++) begin
      rop  = 2'($urandom_range(0, 3));
      rrd  = 5'($urandom_range(0, 31));
      ra   = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      rdat = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      build(rop, rrd, ra, rdat);
      issue(rop, rrd, ra, rdat, 1'b0);
      drain(int'($urandom_range(0, 2)), 99);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
